// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder built from chained full-adder stages, with
// combinational sum/carry/overflow outputs and a registered copy of each.
module ripple_carry_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       a0,
  input  logic       a1,
  input  logic       a2,
  input  logic       a3,
  input  logic       b0,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       cin,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       cout,
  output logic       ovf,
  output logic [3:0] sum_q,
  output logic       cout_q,
  output logic       ovf_q
);

  localparam int unsigned W = 4;

  logic [W-1:0] a_v;
  logic [W-1:0] b_v;
  logic [W-1:0] s_v;
  logic [W:0]   c;

  assign a_v = {a3, a2, a1, a0};
  assign b_v = {b3, b2, b1, b0};

  // Carry chain: c[i] feeds stage i, c[W] is the carry out of the MSB.
  always_comb begin
    c    = '0;
    s_v  = '0;
    c[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      s_v[i]   = a_v[i] ^ b_v[i] ^ c[i];
      c[i + 1] = (a_v[i] & b_v[i]) | (a_v[i] & c[i]) | (b_v[i] & c[i]);
    end
  end

  assign s0   = s_v[0];
  assign s1   = s_v[1];
  assign s2   = s_v[2];
  assign s3   = s_v[3];
  assign cout = c[W];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf  = c[W] ^ c[W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= s_v;
      cout_q <= c[W];
      ovf_q  <= c[W] ^ c[W-1];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder: directed table, exhaustive and
// random sweeps against an arithmetic reference, and async reset sequences.
module tb_ripple_carry_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
  logic       b0 = 1'b0, b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
  logic       cin = 1'b0;
  logic       s0, s1, s2, s3, cout, ovf;
  logic [3:0] sum_q;
  logic       cout_q, ovf_q;
  logic [3:0] s_vec;

  int total = 0;
  int bad   = 0;

  logic [3:0] last_a = 4'd0;
  logic [3:0] last_b = 4'd0;
  logic       last_c = 1'b0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl [7];

  ripple_carry_adder dut (
    .clk(clk), .rst(rst),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .cin(cin),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .cout(cout), .ovf(ovf),
    .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q)
  );

  assign s_vec = {s3, s2, s1, s0};

  always #5 clk = ~clk;

  // Reference: unsigned sum for {cout,s}, signed range test for ovf.
  function automatic logic [5:0] ref_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic c);
    int u, sa, sb, sr;
    logic [4:0] r;
    logic ov;
    u  = int'(a) + int'(b) + int'(c);
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    sr = sa + sb + int'(c);
    ov = (sr > 7) || (sr < -8);
    r  = 5'(u);
    return {ov, r};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    {a3, a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
    cin = c;
    last_a = a;
    last_b = b;
    last_c = c;
  endtask

  // Drive at negedge; check combinational result against the model and the
  // registered outputs against the vector captured at the preceding posedge.
  task automatic apply_chk(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [5:0] prev, cur;
    prev = ref_add(last_a, last_b, last_c);
    @(negedge clk);
    drive(a, b, c);
    #1;
    cur = ref_add(a, b, c);
    chk("s", 8'(s_vec), 8'(cur[3:0]));
    chk("cout", 8'(cout), 8'(cur[4]));
    chk("ovf", 8'(ovf), 8'(cur[5]));
    chk("sum_q_lag", 8'(sum_q), 8'(prev[3:0]));
    chk("cout_q_lag", 8'(cout_q), 8'(prev[4]));
    chk("ovf_q_lag", 8'(ovf_q), 8'(prev[5]));
  endtask

  initial begin
    tbl[0] = '{a: 4'h0, b: 4'h0, c: 1'b0, s: 4'h0, co: 1'b0, ov: 1'b0};
    tbl[1] = '{a: 4'h8, b: 4'h8, c: 1'b0, s: 4'h0, co: 1'b1, ov: 1'b1};
    tbl[2] = '{a: 4'hF, b: 4'hF, c: 1'b1, s: 4'hF, co: 1'b1, ov: 1'b0};
    tbl[3] = '{a: 4'hF, b: 4'h0, c: 1'b1, s: 4'h0, co: 1'b1, ov: 1'b0};
    tbl[4] = '{a: 4'h7, b: 4'h1, c: 1'b0, s: 4'h8, co: 1'b0, ov: 1'b1};
    tbl[5] = '{a: 4'h5, b: 4'h3, c: 1'b0, s: 4'h8, co: 1'b0, ov: 1'b1};
    tbl[6] = '{a: 4'hC, b: 4'hC, c: 1'b0, s: 4'h8, co: 1'b1, ov: 1'b0};

    // Reset state, including across a clock edge.
    drive(4'h0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_sum_q", 8'(sum_q), 8'h0);
    chk("rst_cout_q", 8'(cout_q), 8'h0);
    chk("rst_ovf_q", 8'(ovf_q), 8'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: combinational now, registered one edge later.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(tbl[i].a, tbl[i].b, tbl[i].c);
      #1;
      chk("tbl_s", 8'(s_vec), 8'(tbl[i].s));
      chk("tbl_cout", 8'(cout), 8'(tbl[i].co));
      chk("tbl_ovf", 8'(ovf), 8'(tbl[i].ov));
      @(posedge clk);
      #1;
      chk("tbl_sum_q", 8'(sum_q), 8'(tbl[i].s));
      chk("tbl_cout_q", 8'(cout_q), 8'(tbl[i].co));
      chk("tbl_ovf_q", 8'(ovf_q), 8'(tbl[i].ov));
    end

    // Exhaustive sweep of A, B, cin.
    for (int n = 0; n < 512; n++) begin
      apply_chk(4'(n >> 5), 4'(n >> 1), 1'(n));
    end

    // Random vectors.
    for (int n = 0; n < 200; n++) begin
      apply_chk(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    end

    // Inputs wiggling between edges move only the combinational outputs.
    @(negedge clk);
    drive(4'h2, 4'h3, 1'b0);
    @(posedge clk);
    #2;
    drive(4'h9, 4'h9, 1'b1);
    #1;
    chk("mid_s", 8'(s_vec), 8'h3);
    chk("mid_cout", 8'(cout), 8'h1);
    chk("mid_sum_q_hold", 8'(sum_q), 8'h5);
    chk("mid_cout_q_hold", 8'(cout_q), 8'h0);
    #2;
    drive(4'h4, 4'h4, 1'b0);
    #1;
    chk("mid2_s", 8'(s_vec), 8'h8);
    chk("mid2_ovf", 8'(ovf), 8'h1);
    chk("mid2_sum_q_hold", 8'(sum_q), 8'h5);
    chk("mid2_ovf_q_hold", 8'(ovf_q), 8'h0);

    // Async reset mid-cycle with 6+5 held.
    @(negedge clk);
    drive(4'h6, 4'h5, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_sum_q", 8'(sum_q), 8'hB);
    chk("pre_rst_ovf_q", 8'(ovf_q), 8'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sum_q", 8'(sum_q), 8'h0);
    chk("arst_cout_q", 8'(cout_q), 8'h0);
    chk("arst_ovf_q", 8'(ovf_q), 8'h0);
    chk("arst_s", 8'(s_vec), 8'hB);
    chk("arst_ovf", 8'(ovf), 8'h1);
    @(posedge clk);
    #1;
    chk("rst_hold_sum_q", 8'(sum_q), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_sum_q", 8'(sum_q), 8'h0);
    @(posedge clk);
    #1;
    chk("restore_sum_q", 8'(sum_q), 8'hB);
    chk("restore_cout_q", 8'(cout_q), 8'h0);
    chk("restore_ovf_q", 8'(ovf_q), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 4 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  system clock; registers update on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset for all registered outputs.
REQ-005 a0, a1, a2, a3  input  1 each  operand A bits; a0 is the LSB (weight 2^0) and a3 is the MSB (weight 2^3).
REQ-006 b0, b1, b2, b3  input  1 each  operand B bits, with the same weighting as A.
REQ-007 cin  input  1  carry into bit 0.
REQ-008 s0, s1, s2, s3  output  1 each  combinational sum bits; s0 is the LSB.
REQ-009 cout  output  1  combinational carry out of bit 3.
REQ-010 ovf  output  1  combinational two's-complement overflow flag.
REQ-011 sum_q  output  4  registered copy of {s3,s2,s1,s0}.
REQ-012 cout_q  output  1  registered copy of cout.
REQ-013 ovf_q  output  1  registered copy of ovf.

Function
REQ-014 The block SHALL compute {cout,s3,s2,s1,s0} = A + B + cin as an unsigned 5-bit result, where A = {a3,a2,a1,a0} and B = {b3,b2,b1,b0}.
REQ-015 The adder SHALL be four chained full-adder stages, each with s_i = a_i ^ b_i ^ c_i and c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i, where c_0 = cin and cout = c_4.
REQ-016 s0..s3, cout and ovf SHALL be purely combinational: zero cycles of latency, no dependence on clk or rst, and no latches.
REQ-017 ovf SHALL equal c_3 ^ c_4, i.e. signed overflow when A and B are treated as 4-bit two's-complement values.
REQ-018 On every rising clk edge with rst low, the block SHALL load sum_q <= {s3,s2,s1,s0}, cout_q <= cout and ovf_q <= ovf.
REQ-019 The registered outputs SHALL therefore lag the combinational outputs by exactly one cycle; there is no enable and no handshake.
REQ-020 Wrap-around behaviour: a result of 16 or more SHALL yield the sum modulo 16 on s3..s0 with cout=1, and the maximum case 15+15+1=31 SHALL give sum 1111 with cout=1.
REQ-021 Inputs that change between clock edges SHALL affect only the combinational outputs until the next rising edge.

Reset
REQ-022 While rst is high, sum_q=0000, cout_q=0 and ovf_q=0 SHALL hold immediately, asynchronously to clk.
REQ-023 Asserting rst mid-operation SHALL clear the registered outputs immediately and leave the combinational outputs unaffected.
REQ-024 After rst deasserts, the first rising clk edge SHALL capture the current combinational result.
REQ-025 No X values SHALL be present on any output after reset when all inputs are driven.

Verification
REQ-026 A=0000, B=0000, cin=0 -> s=0000, cout=0, ovf=0; one edge later sum_q=0000, cout_q=0.
REQ-027 A=1000, B=1000, cin=0 (8+8) -> s=0000, cout=1, ovf=1; after one edge sum_q=0000, cout_q=1, ovf_q=1.
REQ-028 A=1111, B=1111, cin=1 -> s=1111, cout=1, ovf=0.
REQ-029 A=1111, B=0000, cin=1 (full ripple) -> s=0000, cout=1, ovf=0; A=0111, B=0001, cin=0 -> s=1000, cout=0, ovf=1.
REQ-030 Exhaustive sweep of all 512 combinations of A, B and cin -> {cout,s} equals A+B+cin and ovf matches the signed-overflow reference in every case; sum_q, cout_q and ovf_q equal the previous cycle's values.
REQ-031 Assert rst between clock edges while A=0110, B=0101 (sum_q=1011) -> sum_q, cout_q and ovf_q go to 0 at once while s stays 1011; after rst deasserts, the first edge restores sum_q=1011.
